// File: rtl/bomb_game_pkg.sv
// Shared game constants and state encodings (also used by the LED/SSD logic).
package bomb_game_pkg;

  localparam int unsigned POS_W       = 10;
  localparam int unsigned SCORE_W     = 4;
  localparam int unsigned CALC_W      = 11;
  localparam int unsigned LFSR_W      = 16;
  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned SCREEN_H    = 480;
  localparam int unsigned PLACE_X_OFF = 64;
  localparam int unsigned PLACE_Y_OFF = 48;

  typedef enum logic [1:0] {
    QI      = 2'b00,
    QGAME_1 = 2'b01,
    QGAME_2 = 2'b10,
    QDONE   = 2'b11
  } game_state_t;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16/14/13/11.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] q
);

  logic feedback;

  // Feedback from taps 16, 14, 13, 11 (bits 15, 13, 12, 10)
  always_comb begin
    feedback = q[15] ^ q[13] ^ q[12] ^ q[10];
  end

  // Shift every clock so placement depends on when the player acts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= SEED;
    end else begin
      q <= {q[14:0], feedback};
    end
  end

endmodule

// File: rtl/bomb_game_ctrl.sv
// Game FSM: turns, scoring, bomb placement and hit detection.
module bomb_game_ctrl
  import bomb_game_pkg::*;
#(
  parameter int unsigned BOMB_RAD    = 15,
  parameter int unsigned HIT_DIST    = 25,
  parameter int unsigned WIN_SCORE   = 10,
  parameter int unsigned ROUND_TICKS = 600,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tick,
  input  logic               start,
  input  logic [POS_W-1:0]   pos_x,
  input  logic [POS_W-1:0]   pos_y,
  output logic [1:0]         state,
  output logic [POS_W-1:0]   bomb_x,
  output logic [POS_W-1:0]   bomb_y,
  output logic [POS_W-1:0]   bomb_rad,
  output logic               bomb_visible,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               hit
);

  localparam int unsigned TIMER_W = $clog2(ROUND_TICKS + 1);

  game_state_t         state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [SCORE_W-1:0]  p1_d, p2_d, active_score, active_inc;
  logic [POS_W-1:0]    bomb_x_d, bomb_y_d;
  logic                hit_d, visible_d;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [CALC_W-1:0]   place_x, place_y;
  logic [CALC_W-1:0]   dx, dy, adx, ady;
  logic                hit_c;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .q       (lfsr_q)
  );

  // Candidate bomb position from the current LFSR value
  always_comb begin
    place_x = CALC_W'(PLACE_X_OFF) + CALC_W'(lfsr_q[8:0]);
    place_y = CALC_W'(PLACE_Y_OFF) + CALC_W'(lfsr_q[15:8]) + CALC_W'(lfsr_q[15:9]);
  end

  // Inclusive per-axis hit window on 11-bit signed differences
  always_comb begin
    dx    = CALC_W'(pos_x) - CALC_W'(bomb_x);
    dy    = CALC_W'(pos_y) - CALC_W'(bomb_y);
    adx   = dx[CALC_W-1] ? CALC_W'(~dx + CALC_W'(1)) : dx;
    ady   = dy[CALC_W-1] ? CALC_W'(~dy + CALC_W'(1)) : dy;
    hit_c = (adx <= CALC_W'(HIT_DIST)) && (ady <= CALC_W'(HIT_DIST));
  end

  // Saturating increment of the active player's score
  always_comb begin
    active_score = (state_q == QGAME_2) ? p2_score : p1_score;
    active_inc   = (active_score >= SCORE_W'(WIN_SCORE)) ? active_score
                                                         : active_score + SCORE_W'(1);
  end

  // Next-state and next-output logic; everything but the LFSR holds without tick
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    p1_d      = p1_score;
    p2_d      = p2_score;
    bomb_x_d  = bomb_x;
    bomb_y_d  = bomb_y;
    hit_d     = 1'b0;
    if (tick) begin
      case (state_q)
        QI: begin
          if (start) begin
            state_d  = QGAME_1;
            p1_d     = '0;
            p2_d     = '0;
            timer_d  = TIMER_W'(ROUND_TICKS);
            bomb_x_d = POS_W'(place_x);
            bomb_y_d = POS_W'(place_y);
          end
        end
        QGAME_1, QGAME_2: begin
          if (!start) begin
            state_d = QI;
          end else if (hit_c) begin
            hit_d = 1'b1;
            if (state_q == QGAME_1) p1_d = active_inc;
            else                    p2_d = active_inc;
            if (active_inc == SCORE_W'(WIN_SCORE)) begin
              state_d = QDONE;
            end else begin
              timer_d  = TIMER_W'(ROUND_TICKS);
              bomb_x_d = POS_W'(place_x);
              bomb_y_d = POS_W'(place_y);
            end
          end else if (timer_q == TIMER_W'(1)) begin
            state_d  = (state_q == QGAME_1) ? QGAME_2 : QGAME_1;
            timer_d  = TIMER_W'(ROUND_TICKS);
            bomb_x_d = POS_W'(place_x);
            bomb_y_d = POS_W'(place_y);
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
        QDONE: begin
          if (!start) state_d = QI;
        end
        default: state_d = QI;
      endcase
    end
    visible_d = (state_d == QGAME_1) || (state_d == QGAME_2);
  end

  // Game registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= QI;
      timer_q      <= TIMER_W'(ROUND_TICKS);
      p1_score     <= '0;
      p2_score     <= '0;
      bomb_x       <= POS_W'(SCREEN_W / 2);
      bomb_y       <= POS_W'(SCREEN_H / 2);
      hit          <= 1'b0;
      bomb_visible <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      p1_score     <= p1_d;
      p2_score     <= p2_d;
      bomb_x       <= bomb_x_d;
      bomb_y       <= bomb_y_d;
      hit          <= hit_d;
      bomb_visible <= visible_d;
    end
  end

  assign state    = state_q;
  assign bomb_rad = POS_W'(BOMB_RAD);

endmodule
